// File: rtl/seg_mux_n_if.sv
// seg_mux_n_if: display-path bundle between the counter logic and the
// multiplexed 7-segment driver.
//   master : counter/control side (drives digit values and controls)
//   slave  : seg_mux_n (drives SEG/DP/AN/FRAME_TICK)
interface seg_mux_n_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  EN;
  logic [4*DIGITS-1:0]   DIGITS_IN;
  logic [DIGITS-1:0]     BLINK_MASK;
  logic [DIGITS-1:0]     BLANK_MASK;
  logic [DIGITS-1:0]     DP_IN;
  logic                  HEX_MODE;
  logic                  LZ_BLANK;
  logic [6:0]            SEG;
  logic                  DP;
  logic [DIGITS-1:0]     AN;
  logic                  FRAME_TICK;

  modport master (
    output EN, DIGITS_IN, BLINK_MASK, BLANK_MASK, DP_IN, HEX_MODE, LZ_BLANK,
    input  SEG, DP, AN, FRAME_TICK
  );

  modport slave (
    input  EN, DIGITS_IN, BLINK_MASK, BLANK_MASK, DP_IN, HEX_MODE, LZ_BLANK,
    output SEG, DP, AN, FRAME_TICK
  );
endinterface

// File: rtl/seg_mux_n.sv
// seg_mux_n: N-digit multiplexed 7-segment driver with per-digit blink,
// blank and decimal point, leading-zero suppression and hex decode.
// Inputs are captured into a shadow register once per frame so a scan
// never mixes old and new digit values.
//   CLK        system clock
//   RESET_N    asynchronous active-low reset, release synchronised internally
//   bus.EN / DIGITS_IN / BLINK_MASK / BLANK_MASK / DP_IN / HEX_MODE / LZ_BLANK
//              display data and controls (sampled at frame wrap)
//   bus.SEG / DP / AN  registered, active-low display drive
//   bus.FRAME_TICK     one-cycle pulse when the scan wraps to slot 0
module seg_mux_n #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 16384,
  parameter int unsigned BLINK_DIV   = 8388608
) (
  input logic        CLK,
  input logic        RESET_N,
  seg_mux_n_if.slave bus
);

  localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [1:0]          rst_sync;
  logic                run;
  logic                advance;

  logic [RCNT_W-1:0]   rcnt;
  logic [BCNT_W-1:0]   bcnt;
  logic [SLOT_W-1:0]   slot;
  logic                blink_on;

  logic [4*DIGITS-1:0] sh_digits;
  logic [DIGITS-1:0]   sh_blink;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_hex;
  logic                sh_lz;

  logic                r_tc;
  logic                b_tc;
  logic                wrap;

  logic [3:0]          cur_val_c;
  logic                cur_blink_c;
  logic                cur_blank_c;
  logic                cur_dp_c;
  logic [DIGITS-1:0]   sel_c;
  logic                upper_nz_c;
  logic                off_c;

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                tick_q;

  // Active-low segment decode; 10..15 show letters in hex mode, dash otherwise.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
    case (v)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = hex ? 7'b0001000 : SEG_DASH;
      4'hB:    decode = hex ? 7'b0000011 : SEG_DASH;
      4'hC:    decode = hex ? 7'b1000110 : SEG_DASH;
      4'hD:    decode = hex ? 7'b0100001 : SEG_DASH;
      4'hE:    decode = hex ? 7'b0000110 : SEG_DASH;
      default: decode = hex ? 7'b0001110 : SEG_DASH;
    endcase
  endfunction

  // Two-flop reset release; counting is enabled once the chain is full.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run     = rst_sync[1];
  assign advance = run & bus.EN;

  assign r_tc = (rcnt == RCNT_W'(REFRESH_DIV - 1));
  assign b_tc = (bcnt == BCNT_W'(BLINK_DIV - 1));
  assign wrap = r_tc & (slot == SLOT_W'(DIGITS - 1));

  // Refresh/slot and blink timebases; both freeze while EN is low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rcnt     <= '0;
      bcnt     <= '0;
      slot     <= '0;
      blink_on <= 1'b1;
    end else if (advance) begin
      rcnt <= r_tc ? '0 : rcnt + RCNT_W'(1);
      bcnt <= b_tc ? '0 : bcnt + BCNT_W'(1);
      if (r_tc) slot <= wrap ? '0 : slot + SLOT_W'(1);
      if (b_tc) blink_on <= ~blink_on;
    end
  end

  // Frame-synchronous shadow of all display inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_digits <= '0;
      sh_blink  <= '0;
      sh_blank  <= '0;
      sh_dp     <= '0;
      sh_hex    <= 1'b0;
      sh_lz     <= 1'b0;
    end else if (advance && wrap) begin
      sh_digits <= bus.DIGITS_IN;
      sh_blink  <= bus.BLINK_MASK;
      sh_blank  <= bus.BLANK_MASK;
      sh_dp     <= bus.DP_IN;
      sh_hex    <= bus.HEX_MODE;
      sh_lz     <= bus.LZ_BLANK;
    end
  end

  // Select the current slot's digit and decide whether it is dark.
  always_comb begin
    cur_val_c   = 4'd0;
    cur_blink_c = 1'b0;
    cur_blank_c = 1'b0;
    cur_dp_c    = 1'b0;
    sel_c       = '0;
    upper_nz_c  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (slot == SLOT_W'(i)) begin
        cur_val_c   = sh_digits[4*i +: 4];
        cur_blink_c = sh_blink[i];
        cur_blank_c = sh_blank[i];
        cur_dp_c    = sh_dp[i];
        sel_c[i]    = 1'b1;
      end
      // Any nonzero digit at or above this slot stops leading-zero blanking.
      if ((SLOT_W'(i) >= slot) && (sh_digits[4*i +: 4] != 4'd0)) upper_nz_c = 1'b1;
    end
    off_c = cur_blank_c
          | (cur_blink_c & ~blink_on)
          | (sh_lz & (slot != '0) & ~upper_nz_c);
  end

  // Registered display drive, one cycle behind the slot/blink state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else if (!advance) begin
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= off_c ? SEG_OFF : decode(cur_val_c, sh_hex);
      dp_q   <= off_c | ~cur_dp_c;
      an_q   <= off_c ? '1 : ~sel_c;
      tick_q <= wrap;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.AN         = an_q;
  assign bus.FRAME_TICK = tick_q;

endmodule
